seq101_arb: RTL

Round-robin scheduler that shares one overlapping "101" Moore sequence detector between two serial bit-stream requesters. It grants the detector to one requester per frame of FRAME_LEN accepted bits and resets the detector at every frame start, so patterns never span frames. It keeps a saturating hit counter per requester. It sits between the serial front-end sources and the status/interrupt logic that reads the counters.

---
 rtl/seq101_arb_if.sv | 27 ++
 rtl/seq101_arb.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/seq101_arb_if.sv
// Bundle of the requester-side bit streams and the status outputs of seq101_arb.
// The master side drives requests and data; the slave side is the scheduler.
interface seq101_arb_if #(
    parameter int unsigned CW = 8
);
    logic [1:0]    req;
    logic [1:0]    valid;
    logic [1:0]    din;
    logic          cnt_clr;
    logic [1:0]    gnt;
    logic          owner;
    logic          det_y;
    logic          frame_done;
    logic          aborted;
    logic [CW-1:0] hit_cnt0;
    logic [CW-1:0] hit_cnt1;

    modport master (
        output req, valid, din, cnt_clr,
        input  gnt, owner, det_y, frame_done, aborted, hit_cnt0, hit_cnt1
    );

    modport slave (
        input  req, valid, din, cnt_clr,
        output gnt, owner, det_y, frame_done, aborted, hit_cnt0, hit_cnt1
    );
endinterface

// File: rtl/seq101_arb.sv
// Round-robin sharing of one overlapping "101" Moore detector between two serial
// requesters, one frame of FRAME_LEN accepted bits per grant, with saturating hit counters.
module seq101_arb #(
    parameter int unsigned FRAME_LEN = 8,
    parameter int unsigned CW        = 8
) (
    input  logic         clk,
    input  logic         rst,
    seq101_arb_if.slave  bus
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        DET_S0 = 2'd0,
        DET_S1 = 2'd1,
        DET_S2 = 2'd2,
        DET_S3 = 2'd3
    } det_t;

    localparam logic [7:0]    LAST_IDX = 8'(FRAME_LEN - 1);
    localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};
    localparam logic [CW-1:0] CNT_ONE  = CW'(1'b1);

    state_t        r_state;
    state_t        w_state_nxt;
    det_t          r_det;
    det_t          w_det_nxt;
    logic [7:0]    r_bitcnt;
    logic [7:0]    w_bitcnt_nxt;
    logic          r_owner;
    logic          w_owner_nxt;
    logic          r_last;
    logic          w_last_nxt;
    logic          r_aborted;
    logic          w_aborted_nxt;
    logic [CW-1:0] r_cnt0;
    logic [CW-1:0] w_cnt0_nxt;
    logic [CW-1:0] r_cnt1;
    logic [CW-1:0] w_cnt1_nxt;

    logic w_own_req;
    logic w_accept;
    logic w_hit;
    logic w_start;

    function automatic det_t det_step(input det_t s, input logic b);
        det_t n;
        case (s)
            DET_S0:  n = b ? DET_S1 : DET_S0;
            DET_S1:  n = b ? DET_S1 : DET_S2;
            DET_S2:  n = b ? DET_S3 : DET_S0;
            DET_S3:  n = b ? DET_S1 : DET_S2;
            default: n = DET_S0;
        endcase
        return n;
    endfunction

    // Only the granted requester's lines matter; everything else is ignored.
    assign w_own_req = bus.req[r_owner];
    assign w_accept  = (r_state == ST_RUN) && w_own_req && bus.valid[r_owner];
    assign w_hit     = w_accept && (r_det == DET_S2) && bus.din[r_owner];
    assign w_start   = (r_state == ST_IDLE) && (bus.req != 2'b00);

    // Controller next-state, detector and bit-counter update.
    always_comb begin
        w_state_nxt   = r_state;
        w_owner_nxt   = r_owner;
        w_last_nxt    = r_last;
        w_det_nxt     = r_det;
        w_bitcnt_nxt  = r_bitcnt;
        w_aborted_nxt = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_start) begin
                    w_state_nxt  = ST_RUN;
                    w_owner_nxt  = (bus.req == 2'b11) ? ~r_last : bus.req[1];
                    w_det_nxt    = DET_S0;
                    w_bitcnt_nxt = 8'd0;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (!w_own_req) begin
                    w_state_nxt   = ST_DONE;
                    w_aborted_nxt = 1'b1;
                end else if (w_accept) begin
                    w_det_nxt    = det_step(r_det, bus.din[r_owner]);
                    w_bitcnt_nxt = r_bitcnt + 8'd1;
                    w_state_nxt  = (r_bitcnt == LAST_IDX) ? ST_DONE : ST_RUN;
                end else begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
                w_last_nxt  = r_owner;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Saturating hit counters; a clear beats a simultaneous increment.
    always_comb begin
        w_cnt0_nxt = r_cnt0;
        w_cnt1_nxt = r_cnt1;
        if (bus.cnt_clr) begin
            w_cnt0_nxt = {CW{1'b0}};
            w_cnt1_nxt = {CW{1'b0}};
        end else if (w_hit && !r_owner && (r_cnt0 != CNT_MAX)) begin
            w_cnt0_nxt = r_cnt0 + CNT_ONE;
        end else if (w_hit && r_owner && (r_cnt1 != CNT_MAX)) begin
            w_cnt1_nxt = r_cnt1 + CNT_ONE;
        end else begin
            w_cnt0_nxt = r_cnt0;
            w_cnt1_nxt = r_cnt1;
        end
    end

    // Controller state register; r_last=1 lets requester 0 win the first tie.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_det     <= DET_S0;
            r_bitcnt  <= 8'd0;
            r_owner   <= 1'b0;
            r_last    <= 1'b1;
            r_aborted <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_det     <= w_det_nxt;
            r_bitcnt  <= w_bitcnt_nxt;
            r_owner   <= w_owner_nxt;
            r_last    <= w_last_nxt;
            r_aborted <= w_aborted_nxt;
        end
    end

    // Hit counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt0 <= {CW{1'b0}};
            r_cnt1 <= {CW{1'b0}};
        end else begin
            r_cnt0 <= w_cnt0_nxt;
            r_cnt1 <= w_cnt1_nxt;
        end
    end

    assign bus.gnt        = (r_state == ST_RUN) ? (r_owner ? 2'b10 : 2'b01) : 2'b00;
    assign bus.owner      = r_owner;
    assign bus.det_y      = (r_det == DET_S3);
    assign bus.frame_done = (r_state == ST_DONE);
    assign bus.aborted    = r_aborted;
    assign bus.hit_cnt0   = r_cnt0;
    assign bus.hit_cnt1   = r_cnt1;
endmodule
